// File: rtl/neo_port_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | neo_port_master                                                            |
// | Non-68K initiator for cartridge PORT-space cycles with programmable timing.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module neo_port_master #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic        CLK_48M,
  input  logic        nRESET,
  input  logic        BUS_GRANT,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_BE,
  input  logic [18:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic        READY,
  output logic        RSP_VALID,
  output logic        RSP_ABORT,
  output logic [15:0] RSP_RDATA,
  output logic [18:0] M68K_ADDR,
  output logic [15:0] M68K_DATA_OUT,
  output logic        M68K_DATA_OE,
  input  logic [15:0] M68K_DATA_IN,
  output logic        nPORTOEL,
  output logic        nPORTOEU,
  output logic        nPORTWEL,
  output logic        nPORTWEU
);

  // A zero length is treated as a single cycle.
  localparam logic [7:0] c_setup  = (SETUP_CYC  < 1) ? 8'd1 : SETUP_CYC[7:0];
  localparam logic [7:0] c_strobe = (STROBE_CYC < 1) ? 8'd1 : STROBE_CYC[7:0];
  localparam logic [7:0] c_hold   = (HOLD_CYC   < 1) ? 8'd1 : HOLD_CYC[7:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [1:0]  r_be;
  logic [15:0] r_rd_cap;

  assign READY = (r_state == S_IDLE) && BUS_GRANT && nRESET;

  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_we          <= 1'b0;
      r_be          <= 2'b00;
      r_rd_cap      <= 16'h0000;
      RSP_VALID     <= 1'b0;
      RSP_ABORT     <= 1'b0;
      RSP_RDATA     <= 16'h0000;
      M68K_ADDR     <= 19'd0;
      M68K_DATA_OUT <= 16'h0000;
      M68K_DATA_OE  <= 1'b0;
      nPORTOEL      <= 1'b1;
      nPORTOEU      <= 1'b1;
      nPORTWEL      <= 1'b1;
      nPORTWEU      <= 1'b1;
    end else begin
      RSP_VALID <= 1'b0;
      RSP_ABORT <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (REQ && BUS_GRANT) begin
            r_we          <= REQ_WE;
            r_be          <= REQ_BE;
            M68K_ADDR     <= REQ_ADDR;
            M68K_DATA_OUT <= REQ_WDATA;
            M68K_DATA_OE  <= REQ_WE;
            r_cnt         <= c_setup;
            r_state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Grant loss is only honoured before any strobe has gone low.
          if (!BUS_GRANT) begin
            RSP_VALID    <= 1'b1;
            RSP_ABORT    <= 1'b1;
            M68K_DATA_OE <= 1'b0;
            r_cnt        <= 8'd1;
            r_state      <= S_DONE;
          end else if (r_cnt <= 8'd1) begin
            nPORTOEU <= r_we | ~r_be[1];
            nPORTOEL <= r_we | ~r_be[0];
            nPORTWEU <= ~r_we | ~r_be[1];
            nPORTWEL <= ~r_we | ~r_be[0];
            r_cnt    <= c_strobe;
            r_state  <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_STROBE: begin
          if (r_cnt <= 8'd1) begin
            nPORTOEL <= 1'b1;
            nPORTOEU <= 1'b1;
            nPORTWEL <= 1'b1;
            nPORTWEU <= 1'b1;
            r_rd_cap <= M68K_DATA_IN & {{8{r_be[1]}}, {8{r_be[0]}}};
            r_cnt    <= c_hold;
            r_state  <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt <= 8'd1) begin
            RSP_VALID    <= 1'b1;
            M68K_DATA_OE <= 1'b0;
            if (!r_we) begin
              RSP_RDATA <= r_rd_cap;
            end
            r_cnt   <= 8'd1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neo_port_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_neo_port_master                                                         |
// | Directed bench: default-timing initiator plus a 1/1/1 timing instance.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_neo_port_master;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        grant = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_be = 2'b00;
  logic [18:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        ready, rsp_valid, rsp_abort, m_oe;
  logic [15:0] rsp_rdata, m_dout, m_din;
  logic [18:0] m_addr;
  logic        oel, oeu, wel, weu;

  logic        f_req = 1'b0;
  logic [1:0]  f_be = 2'b00;
  logic        f_ready, f_valid, f_abort, f_oe;
  logic [15:0] f_rdata, f_dout;
  logic [18:0] f_addr;
  logic        f_oel, f_oeu, f_wel, f_weu;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neo_port_master u_dut (
    .CLK_48M(clk), .nRESET(nreset), .BUS_GRANT(grant),
    .REQ(req), .REQ_WE(req_we), .REQ_BE(req_be), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .READY(ready), .RSP_VALID(rsp_valid), .RSP_ABORT(rsp_abort), .RSP_RDATA(rsp_rdata),
    .M68K_ADDR(m_addr), .M68K_DATA_OUT(m_dout), .M68K_DATA_OE(m_oe), .M68K_DATA_IN(m_din),
    .nPORTOEL(oel), .nPORTOEU(oeu), .nPORTWEL(wel), .nPORTWEU(weu)
  );

  neo_port_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_fast (
    .CLK_48M(clk), .nRESET(nreset), .BUS_GRANT(grant),
    .REQ(f_req), .REQ_WE(1'b0), .REQ_BE(f_be), .REQ_ADDR(19'h12345), .REQ_WDATA(16'h0000),
    .READY(f_ready), .RSP_VALID(f_valid), .RSP_ABORT(f_abort), .RSP_RDATA(f_rdata),
    .M68K_ADDR(f_addr), .M68K_DATA_OUT(f_dout), .M68K_DATA_OE(f_oe), .M68K_DATA_IN(16'hFFFF),
    .nPORTOEL(f_oel), .nPORTOEU(f_oeu), .nPORTWEL(f_wel), .nPORTWEU(f_weu)
  );

  // Cartridge responder model: ID register, RNG advanced at the end of each read, SMA bank latch.
  localparam logic [18:0] ADDR_ID  = 19'h7F223;
  localparam logic [18:0] ADDR_RNG = 19'h7FFFC;
  localparam logic [18:0] ADDR_SMA = 19'h7FFF8;
  logic [15:0] rng = 16'h2345;
  logic [15:0] sma_bank = 16'h0000;
  logic        oe_prev = 1'b0, we_prev = 1'b0;

  assign m_din = (m_addr == ADDR_ID) ? 16'h9A37 : (m_addr == ADDR_RNG) ? rng : 16'h5A5A;

  always @(negedge clk) begin
    if (oe_prev && (oel & oeu) && m_addr == ADDR_RNG) rng <= {rng[14:0], rng[15] ^ rng[14]};
    if (we_prev && (wel & weu) && m_addr == ADDR_SMA) sma_bank <= m_dout;
    oe_prev <= ~(oel & oeu);
    we_prev <= ~(wel & weu);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          first_lo, n_lo, valid_at, bad_pat, first_abs, last_abs;
  logic        abort_seen, oe_lo, oe_done;
  logic [18:0] a_lo;
  logic [15:0] d_lo;

  task automatic run_cycle(input logic we, input logic [1:0] be, input logic [18:0] addr,
                           input logic [15:0] wdata, input int drop_at);
    int w;
    logic [3:0] exp_pat;
    first_lo = -1; n_lo = 0; valid_at = -1; bad_pat = 0; first_abs = -1; last_abs = -1;
    abort_seen = 1'b0; oe_lo = 1'b0; oe_done = 1'b1; a_lo = '0; d_lo = '0;
    exp_pat = we ? {~be, 2'b11} : {2'b11, ~be};
    @(negedge clk);
    req = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      #1;
      if ({weu, wel, oeu, oel} != 4'hF) begin
        if (first_lo < 0) begin
          first_lo = k; first_abs = cyc; a_lo = m_addr; d_lo = m_dout; oe_lo = m_oe;
        end
        last_abs = cyc;
        n_lo++;
        if ({weu, wel, oeu, oel} != exp_pat) bad_pat++;
      end
      if (rsp_valid) begin
        valid_at = k; abort_seen = rsp_abort; oe_done = m_oe;
        break;
      end
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (k == drop_at) grant = 1'b0;
      @(posedge clk);
    end
    req = 1'b0;
  endtask

  int f_lo, f_va, gap, last1, seen;
  logic f_ab;

  initial begin
    // Reset state
    grant = 1'b1;
    @(posedge clk); #1;
    check("rst_strobes", {weu, wel, oeu, oel}, 4'hF);
    check("rst_oe", m_oe, 1'b0);
    check("rst_addr", m_addr, 19'd0);
    check("rst_dout", m_dout, 16'h0000);
    check("rst_rsp", {rsp_valid, rsp_abort, rsp_rdata}, 18'd0);
    check("rst_ready", ready, 1'b0);
    @(negedge clk); nreset = 1'b1; #1;
    check("ready_after_rst", ready, 1'b1);
    @(negedge clk); grant = 1'b0; #1;
    check("ready_no_grant", ready, 1'b0);
    grant = 1'b1;

    // Back-to-back RNG reads
    run_cycle(1'b0, 2'b11, ADDR_RNG, 16'h0000, 0);
    check("rng1_data", rsp_rdata, 16'h2345);
    check("rng1_nlo", n_lo, 4);
    check("rng1_valid_at", valid_at, 8);
    last1 = last_abs;
    run_cycle(1'b0, 2'b11, ADDR_RNG, 16'h0000, 0);
    check("rng2_data", rsp_rdata, 16'h468A);
    check("rng2_nlo", n_lo, 4);
    gap = first_abs - last1 - 1;
    check("rng_gap", gap, 5);

    // ID reads, full and lower-lane
    run_cycle(1'b0, 2'b11, ADDR_ID, 16'h0000, 0);
    check("id_data", rsp_rdata, 16'h9A37);
    check("id_first_lo", first_lo, 3);
    check("id_nlo", n_lo, 4);
    check("id_pat", bad_pat, 0);
    check("id_abort", abort_seen, 1'b0);
    run_cycle(1'b0, 2'b01, ADDR_ID, 16'h0000, 0);
    check("id_lower_data", rsp_rdata, 16'h0037);
    check("id_lower_pat", bad_pat, 0);

    // SMA bank write
    run_cycle(1'b1, 2'b11, ADDR_SMA, 16'h4000, 0);
    check("wr_first_lo", first_lo, 3);
    check("wr_nlo", n_lo, 4);
    check("wr_valid_at", valid_at, 8);
    check("wr_pat", bad_pat, 0);
    check("wr_addr", a_lo, ADDR_SMA);
    check("wr_dout", d_lo, 16'h4000);
    check("wr_oe_strobe", oe_lo, 1'b1);
    check("wr_oe_done", oe_done, 1'b0);
    check("wr_rdata_kept", rsp_rdata, 16'h0037);
    #2;
    check("sma_p2_offset", {10'd0, sma_bank, 6'd0}, 32'h100000);

    // Grant lost in first SETUP cycle
    run_cycle(1'b0, 2'b11, ADDR_ID, 16'h0000, 1);
    check("abort_valid_at", valid_at, 2);
    check("abort_flag", abort_seen, 1'b1);
    check("abort_nlo", n_lo, 0);
    check("abort_rdata_kept", rsp_rdata, 16'h0037);
    @(negedge clk); grant = 1'b1;

    // Reset during STROBE
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_be = 2'b11; req_addr = 19'h00100; req_wdata = 16'hBEEF;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      #1;
      @(negedge clk);
      req = 1'b0;
      if (k == 4) begin
        check("mid_strobe_low", {weu, wel}, 2'b00);
        nreset = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    check("rst_mid_strobes", {weu, wel, oeu, oel}, 4'hF);
    check("rst_mid_oe", m_oe, 1'b0);
    check("rst_mid_valid", rsp_valid, 1'b0);
    check("rst_mid_ready", ready, 1'b0);
    @(negedge clk); nreset = 1'b1; #1;
    check("rst_mid_ready_after", ready, 1'b1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("rst_mid_no_valid", seen, 0);

    // 1/1/1 timing, BE=00 read
    f_lo = 0; f_va = -1; f_ab = 1'b1;
    @(negedge clk);
    f_req = 1'b1; f_be = 2'b00;
    check("fast_ready", f_ready, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      #1;
      if ({f_weu, f_wel, f_oeu, f_oel} != 4'hF) f_lo++;
      if (f_valid && f_va < 0) begin
        f_va = k; f_ab = f_abort;
      end
      @(negedge clk);
      f_req = 1'b0;
      @(posedge clk);
    end
    check("fast_valid_at", f_va, 4);
    check("fast_no_strobe", f_lo, 0);
    check("fast_abort", f_ab, 1'b0);
    check("fast_rdata", f_rdata, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
